// File: rtl/i2c_reg_bank.sv
// Register bank on the I2C peripheral's application bus: control, user registers,
// maskable W1C interrupt flags, synchronised hardware status and a snapshot counter.
module i2c_reg_bank #(
    parameter logic [7:0] CHIP_ID = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_rdn,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic [7:0]  status,
    input  logic [7:0]  event_i,
    input  logic [7:0]  hw_status_i,
    output logic        irq_o,
    output logic        cnt_en_o,
    output logic [63:0] user_regs_o
);

    localparam logic [7:0] A_ID      = 8'h00;
    localparam logic [7:0] A_CTRL    = 8'h01;
    localparam logic [7:0] A_MASK    = 8'h02;
    localparam logic [7:0] A_FLAGS   = 8'h03;
    localparam logic [7:0] A_HW      = 8'h04;
    localparam logic [7:0] A_CNT_LO  = 8'h05;
    localparam logic [7:0] A_CNT_HI  = 8'h06;

    logic        wr_en;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  flags_q, flags_d;
    logic [7:0]  hw_meta_q, hw_sync_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] snap_q, snap_d;
    logic        irq_q, irq_d;
    logic [7:0]  user_q [8];

    assign wr_en = we & wr_rdn;

    always_comb begin
        ctrl_d  = ctrl_q;
        mask_d  = mask_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        if (wr_en && addr == A_CTRL)
            ctrl_d = wdata[1:0];
        if (wr_en && addr == A_MASK)
            mask_d = wdata;
        if (wr_en && addr == A_FLAGS)
            flags_d = flags_q & ~wdata;
        // Event set is applied after the clear so a colliding set wins.
        flags_d = flags_d | event_i;
        if (wr_en && addr == A_CTRL && wdata[2])
            cnt_d = 16'h0000;
        else if (ctrl_q[1])
            cnt_d = cnt_q + 16'd1;
        if (wr_en && addr == A_CNT_LO)
            snap_d = cnt_q;
        irq_d = ctrl_q[0] & |(flags_q & mask_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            mask_q    <= '0;
            flags_q   <= '0;
            hw_meta_q <= '0;
            hw_sync_q <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            mask_q    <= mask_d;
            flags_q   <= flags_d;
            hw_meta_q <= hw_status_i;
            hw_sync_q <= hw_meta_q;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            irq_q     <= irq_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_user
            localparam logic [7:0] A_USER = 8'(8 + gi);
            logic [7:0] user_d;

            always_comb begin
                user_d = user_q[gi];
                if (wr_en && addr == A_USER)
                    user_d = wdata;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    user_q[gi] <= '0;
                else
                    user_q[gi] <= user_d;
            end

            assign user_regs_o[gi*8 +: 8] = user_q[gi];
        end
    endgenerate

    // Pure decode: the peripheral pre-fetches, so reads must not touch state.
    always_comb begin
        rdata = 8'h00;
        case (addr)
            A_ID:     rdata = CHIP_ID;
            A_CTRL:   rdata = {6'b0, ctrl_q};
            A_MASK:   rdata = mask_q;
            A_FLAGS:  rdata = flags_q;
            A_HW:     rdata = hw_sync_q;
            A_CNT_LO: rdata = snap_q[7:0];
            A_CNT_HI: rdata = snap_q[15:8];
            default: begin
                if (addr[7:3] == 5'b00001)
                    rdata = user_q[addr[2:0]];
            end
        endcase
    end

    assign status   = flags_q & mask_q;
    assign irq_o    = irq_q;
    assign cnt_en_o = ctrl_q[1];

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank with hand-computed expectations.
module tb_i2c_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_rdn = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  rdata;
    logic [7:0]  status;
    logic [7:0]  event_i = 8'h00;
    logic [7:0]  hw_status_i = 8'h00;
    logic        irq_o;
    logic        cnt_en_o;
    logic [63:0] user_regs_o;

    int tests_run = 0;
    int tests_failed = 0;

    i2c_reg_bank #(.CHIP_ID(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata),
        .we(we), .rdata(rdata), .status(status), .event_i(event_i),
        .hw_status_i(hw_status_i), .irq_o(irq_o), .cnt_en_o(cnt_en_o),
        .user_regs_o(user_regs_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1; wr_rdn = 1'b1;
        tick();
        we = 1'b0; wr_rdn = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check_eq(tag, {56'b0, rdata}, {56'b0, exp});
    endtask

    initial begin
        // Reset state
        #2;
        rd_check("rst_id", 8'h00, 8'hA5);
        check_eq("rst_status", {56'b0, status}, 64'h0);
        check_eq("rst_irq", {63'b0, irq_o}, 64'h0);
        check_eq("rst_cnt_en", {63'b0, cnt_en_o}, 64'h0);
        check_eq("rst_user", user_regs_o, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        rd_check("rd_ctrl0", 8'h01, 8'h00);
        rd_check("rd_flags0", 8'h03, 8'h00);
        rd_check("rd_cntlo0", 8'h05, 8'h00);
        rd_check("rd_user0", 8'h08, 8'h00);

        // User registers and unmapped/ignored writes
        for (int i = 0; i < 8; i++) wr(8'(8 + i), 8'(8'h11 * (i + 1)));
        check_eq("user_all", user_regs_o, 64'h8877665544332211);
        wr(8'h07, 8'hFF);
        rd_check("unmapped_07", 8'h07, 8'h00);
        wr(8'h06, 8'hFF);
        rd_check("cnt_hi_ro", 8'h06, 8'h00);
        addr = 8'h08; wdata = 8'hEE; we = 1'b1; wr_rdn = 1'b0;
        tick();
        we = 1'b0;
        rd_check("we_no_wr_rdn", 8'h08, 8'h11);
        wr(8'h01, 8'hF8);
        rd_check("ctrl_hi_bits", 8'h01, 8'h00);

        // Interrupts
        wr(8'h02, 8'h05);
        wr(8'h01, 8'h01);
        event_i = 8'h06;
        tick();
        event_i = 8'h00;
        rd_check("flags_set", 8'h03, 8'h06);
        check_eq("status_masked", {56'b0, status}, 64'h04);
        check_eq("irq_edge_k", {63'b0, irq_o}, 64'h0);
        tick();
        check_eq("irq_edge_k1", {63'b0, irq_o}, 64'h1);
        wr(8'h03, 8'h04);
        rd_check("flags_w1c", 8'h03, 8'h02);
        check_eq("irq_after_w1c", {63'b0, irq_o}, 64'h1);
        tick();
        check_eq("irq_deassert", {63'b0, irq_o}, 64'h0);
        event_i = 8'h04;
        wr(8'h03, 8'h04);
        event_i = 8'h00;
        rd_check("set_wins", 8'h03, 8'h06);

        // Counter and snapshot
        wr(8'h01, 8'h02);
        check_eq("cnt_en_o", {63'b0, cnt_en_o}, 64'h1);
        repeat (100) tick();
        wr(8'h05, 8'h00);
        rd_check("snap_lo", 8'h05, 8'h64);
        rd_check("snap_hi", 8'h06, 8'h00);
        repeat (5) tick();
        rd_check("snap_stable", 8'h05, 8'h64);
        wr(8'h01, 8'h06);
        rd_check("ctrl_clr_reads", 8'h01, 8'h02);
        wr(8'h05, 8'h00);
        rd_check("clr_snap_lo", 8'h05, 8'h00);
        rd_check("clr_snap_hi", 8'h06, 8'h00);
        repeat (65534) tick();
        wr(8'h05, 8'h00);
        rd_check("max_lo", 8'h05, 8'hFF);
        rd_check("max_hi", 8'h06, 8'hFF);
        wr(8'h05, 8'h00);
        rd_check("wrap_lo", 8'h05, 8'h00);
        rd_check("wrap_hi", 8'h06, 8'h00);

        // Hardware status synchroniser latency
        addr = 8'h04;
        #2;
        hw_status_i = 8'h3C;
        #1;
        check_eq("hw_edge0", {56'b0, rdata}, 64'h00);
        tick();
        check_eq("hw_edge1", {56'b0, rdata}, 64'h00);
        tick();
        check_eq("hw_edge2", {56'b0, rdata}, 64'h3C);

        // Reset in the middle of a write
        addr = 8'h09; wdata = 8'h5A; we = 1'b1; wr_rdn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_user", user_regs_o, 64'h0);
        check_eq("mid_rst_status", {56'b0, status}, 64'h0);
        check_eq("mid_rst_irq", {63'b0, irq_o}, 64'h0);
        check_eq("mid_rst_cnt_en", {63'b0, cnt_en_o}, 64'h0);
        tick();
        rd_check("mid_rst_09", 8'h09, 8'h00);
        rd_check("mid_rst_id", 8'h00, 8'hA5);
        addr = 8'h09;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        we = 1'b0; wr_rdn = 1'b0;
        rd_check("first_wr_after_rst", 8'h09, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Application-side register bank that sits directly downstream of the I2C peripheral and consumes its application bus (`addr`, `wdata`, `we`, `wr_rdn`), returning `rdata` and `status`. It holds control and user registers, sticky interrupt flags with mask and write-1-to-clear semantics, a synchronised hardware-status view, and a 16-bit cycle counter with a snapshot capture. It drives `irq_o` and the configuration outputs into the rest of the chip.

## Interface
- `CHIP_ID`, default 8'hA5: value returned at address 0x00.
- `clk` input 1: system clock; same clock as the I2C peripheral.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_rdn` input 1: 1 = write transaction in progress; writes commit only when high.
- `addr` input 8: register address from the peripheral.
- `wdata` input 8: write data, valid in the `we` cycle.
- `we` input 1: single-cycle write strobe.
- `rdata` output 8: read data for `addr`; combinational.
- `status` output 8: `IRQ_FLAGS & IRQ_MASK`; combinational.
- `event_i` input 8: synchronous single-cycle event pulses; bit n sets flag n.
- `hw_status_i` input 8: asynchronous hardware status levels.
- `irq_o` output 1: registered interrupt request.
- `cnt_en_o` output 1: mirror of CTRL[1].
- `user_regs_o` output 64: USER0..USER7, with USER0 at [7:0].

## Operation
- The write condition is `we && wr_rdn`. It takes effect at the same clock edge. `we` with `wr_rdn` = 0 is ignored.
- Register map. All other addresses read 0x00 and ignore writes.
  - 0x00 ID: RO, `CHIP_ID`.
  - 0x01 CTRL: RW, reset 0x00.
    - [0] irq_en.
    - [1] cnt_en.
    - [2] cnt_clr: self-clearing, always reads 0.
    - [7:3] read 0; writes to them are ignored.
  - 0x02 IRQ_MASK: RW, reset 0x00.
  - 0x03 IRQ_FLAGS: reset 0x00.
    - Flag n is set when `event_i[n]` = 1.
    - Writing 1 to bit n clears flag n; writing 0 has no effect.
    - If set and clear hit the same bit in the same cycle, set wins and the flag is 1.
  - 0x04 HW_STATUS: RO, `hw_status_i` through a 2-flop synchroniser per bit; the synchroniser resets to 0x00.
  - 0x05 CNT_LO: a write of any value captures the live counter into SNAP[15:0]. Reads return SNAP[7:0].
  - 0x06 CNT_HI: RO, SNAP[15:8]. Writes are ignored.
  - 0x08–0x0F USER0..7: RW, reset 0x00.
- Counter CNT, 16-bit, reset 0x0000.
  - Priority: clear > increment.
  - Cleared when a CTRL write has bit2 = 1.
  - Otherwise increments by 1 each cycle while cnt_en = 1.
  - Wraps 0xFFFF → 0x0000.
- Snapshot SNAP, 16-bit, reset 0x0000. It captures the CNT value present before that edge's update.
- `irq_o` is registered: `irq_o <= irq_en & |(IRQ_FLAGS & IRQ_MASK)`, using register values before the edge's update. Reset value 0.
- Reads have no side effects, since the peripheral pre-fetches `rdata` speculatively.

## Timing
- `rdata`: zero latency from `addr`. A value written at edge k is visible on `rdata` after edge k.
- Event to flag: an `event_i` pulse in cycle k makes the flag visible on `rdata`/`status` after edge k. `irq_o` asserts after edge k+1.
- A W1C write clearing the last enabled flag deasserts `irq_o` one edge later.
- `hw_status_i` to `rdata`: 2 edges of latency.
- Reset values, asserted asynchronously:
  - `rdata` = `CHIP_ID` when `addr` = 0x00.
  - `status` = 0x00, `irq_o` = 0, `cnt_en_o` = 0, `user_regs_o` = 0.
- Reset asserted mid-transaction discards any pending write and restores every register.
- After `rst_n` deasserts, the first write is accepted on the first `we` edge.

## Test plan
- Reset, then read 0x00 → `rdata` = 0xA5. Read 0x01, 0x03, 0x05, 0x08 → 0x00. `irq_o` = 0.
- Write USER 0x08..0x0F = 0x11..0x88 with `we`/`wr_rdn` = 1 → `user_regs_o` = 0x8877665544332211. A write to 0x07 reads back 0x00. A `we` with `wr_rdn` = 0 to 0x08 changes nothing.
- Interrupts, in order:
  - IRQ_MASK = 0x05, CTRL = 0x01, pulse `event_i` = 0x06 → IRQ_FLAGS = 0x06, `status` = 0x04, `irq_o` = 1 two edges after the pulse.
  - Write 0x04 to 0x03 → flags 0x02, `irq_o` = 0.
  - Same-cycle `event_i[2]` plus W1C of bit2 → flag stays 1.
- Counter:
  - CTRL = 0x02, wait 100 cycles, write 0x05 → CNT_LO/CNT_HI read the captured value; it is stable while CNT keeps running.
  - CTRL = 0x06 → CNT = 0 and CTRL reads 0x02.
  - Force CNT to 0xFFFF → next value 0x0000.
- Drive `hw_status_i` = 0x3C asynchronously → reads at 0x04 return 0x3C within 2 edges, never earlier than 2.
- Assert `rst_n` low while `we` is high mid-write → all registers are at reset values and the write is not committed.
